// File: rtl/pipelined_alu.sv
// pipelined_alu: ALU with a valid/ready handshake and PIPE_STAGES register stages.
// The whole operation is evaluated in front of stage 1. The remaining stages
// carry the result and flags unchanged, which fixes the output timing.
// Optional feature: define PIPELINED_ALU_SAT_EN to make opcode 111 a saturating
// signed add. When it is undefined, opcode 111 is reported as illegal.
module pipelined_alu #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned OP_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [OP_WIDTH-1:0]   in_op,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic                  out_z,
  output logic                  out_n,
  output logic                  out_c,
  output logic                  out_v,
  output logic                  out_err
);

  localparam int unsigned MSB  = DATA_WIDTH - 1;
  localparam int unsigned LAST = PIPE_STAGES - 1;
  localparam int unsigned FW   = 5;  // {z, n, c, v, err}

  logic                  valid_q [PIPE_STAGES];
  logic                  valid_d [PIPE_STAGES];
  logic [DATA_WIDTH-1:0] x_q     [PIPE_STAGES];
  logic [DATA_WIDTH-1:0] x_d     [PIPE_STAGES];
  logic [FW-1:0]         f_q     [PIPE_STAGES];
  logic [FW-1:0]         f_d     [PIPE_STAGES];

  logic                  adv;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic                  add_ovf;
  logic                  sub_ovf;
  logic [DATA_WIDTH-1:0] alu_x;
  logic                  alu_c;
  logic                  alu_v;
  logic                  alu_err;
  logic [FW-1:0]         alu_f;

  // Stall control: the pipeline moves only when the output slot is free or being taken
  always_comb begin
    adv      = !valid_q[LAST] || out_ready;
    in_ready = adv && !reset;
  end

  // Operation evaluation and flag generation for the incoming operands
  always_comb begin
    sum     = {1'b0, in_a} + {1'b0, in_b};
    diff    = {1'b0, in_a} - {1'b0, in_b};
    add_ovf = (in_a[MSB] == in_b[MSB]) && (sum[MSB] != in_a[MSB]);
    sub_ovf = (in_a[MSB] != in_b[MSB]) && (diff[MSB] != in_a[MSB]);
    alu_x   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (in_op)
      3'b000: begin
        alu_x = sum[MSB:0];
        alu_c = sum[DATA_WIDTH];
        alu_v = add_ovf;
      end
      3'b001: begin
        alu_x = diff[MSB:0];
        alu_c = diff[DATA_WIDTH];  // borrow: A < B unsigned
        alu_v = sub_ovf;
      end
      3'b010:  alu_x = ~(in_a | in_b);
      3'b011:  alu_x = in_a | in_b;
      3'b100:  alu_x = ~(in_a & in_b);
      3'b101:  alu_x = in_a & in_b;
      3'b110:  alu_x = in_a ~^ in_b;
      default: begin
`ifdef PIPELINED_ALU_SAT_EN
        // Overflow direction follows the common operand sign
        if (add_ovf) begin
          alu_x = in_a[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                            : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
          alu_x = sum[MSB:0];
        end
        alu_v = add_ovf;
`else
        alu_err = 1'b1;
`endif
      end
    endcase
    alu_f = {alu_x == '0, alu_x[MSB], alu_c, alu_v, alu_err};
  end

  // Next state: load stage 1 and shift the later stages on advance, otherwise hold
  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    f_d     = f_q;
    if (adv) begin
      valid_d[0] = in_valid;
      x_d[0]     = alu_x;
      f_d[0]     = alu_f;
      for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        x_d[i]     = x_q[i-1];
        f_d[i]     = f_q[i-1];
      end
    end
  end

  // Stage registers with synchronous reset that discards every in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
        valid_q[i] <= 1'b0;
        x_q[i]     <= '0;
        f_q[i]     <= '0;
      end
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      f_q     <= f_d;
    end
  end

  // The last stage drives the result port
  always_comb begin
    out_valid = valid_q[LAST];
    out_x     = x_q[LAST];
    {out_z, out_n, out_c, out_v, out_err} = f_q[LAST];
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// tb_pipelined_alu: directed test of pipelined_alu at depths 1, 2 and 4.
// The three instances share their inputs. Single-operation vectors are checked
// on all three. The stream, stall and reset cases are checked on the depth-2 instance.
module tb_pipelined_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_op;
  logic        out_ready;

  logic        ir1, ir2, ir4;
  logic        ov1, ov2, ov4;
  logic [31:0] x1, x2, x4;
  logic        z1, n1, c1, v1, e1;
  logic        z2, n2, c2, v2, e2;
  logic        z4, n4, c4, v4, e4;
  logic [36:0] res1, res2, res4;

  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  pipelined_alu #(.DATA_WIDTH(32), .PIPE_STAGES(1), .OP_WIDTH(3)) u_p1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir1),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov1), .out_ready(out_ready),
    .out_x(x1), .out_z(z1), .out_n(n1), .out_c(c1), .out_v(v1), .out_err(e1));

  pipelined_alu #(.DATA_WIDTH(32), .PIPE_STAGES(2), .OP_WIDTH(3)) u_p2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir2),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov2), .out_ready(out_ready),
    .out_x(x2), .out_z(z2), .out_n(n2), .out_c(c2), .out_v(v2), .out_err(e2));

  pipelined_alu #(.DATA_WIDTH(32), .PIPE_STAGES(4), .OP_WIDTH(3)) u_p4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(ov4), .out_ready(out_ready),
    .out_x(x4), .out_z(z4), .out_n(n4), .out_c(c4), .out_v(v4), .out_err(e4));

  // Result bundles: {x, z, n, c, v, err}
  assign res1 = {x1, z1, n1, c1, v1, e1};
  assign res2 = {x2, z2, n2, c2, v2, e2};
  assign res4 = {x4, z4, n4, c4, v4, e4};

  // Stream vectors with hand-computed results
  logic [2:0]  bp_op  [6] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b000, 3'b110};
  logic [31:0] bp_a   [6] = '{32'h0000_0005, 32'h0000_0003, 32'hF000_0000,
                              32'h1234_5678, 32'h7FFF_FFFF, 32'hAAAA_AAAA};
  logic [31:0] bp_b   [6] = '{32'h0000_0003, 32'h0000_0005, 32'h0000_000F,
                              32'h0000_FFFF, 32'h0000_0001, 32'h5555_5555};
  logic [36:0] bp_exp [6] = '{{32'h0000_0008, 5'b00000}, {32'hFFFF_FFFE, 5'b01100},
                              {32'hF000_000F, 5'b01000}, {32'h0000_5678, 5'b00000},
                              {32'h8000_0000, 5'b01010}, {32'h0000_0000, 5'b10000}};

  int          sent;
  int          got;
  logic        acc;
  logic        take;
  logic [37:0] hold;

  // Count one comparison and report it if it does not match
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // One isolated operation: check the latency and the result at every depth
  task automatic issue_single(input string tag, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [36:0] exp);
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(ir2), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk({tag, "_v1"}, 64'(ov1), 64'(k == 0));
      chk({tag, "_v2"}, 64'(ov2), 64'(k == 1));
      chk({tag, "_v4"}, 64'(ov4), 64'(k == 3));
      if (k == 0) chk({tag, "_x1"}, 64'(res1), 64'(exp));
      if (k == 1) chk({tag, "_x2"}, 64'(res2), 64'(exp));
      if (k == 3) chk({tag, "_x4"}, 64'(res4), 64'(exp));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ir2), 64'(0));
    chk("rst_valid", 64'({ov1, ov2, ov4}), 64'(0));
    chk("rst_res2", 64'(res2), 64'(0));
    chk("rst_res4", 64'(res4), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rise_ready", 64'({ir1, ir2, ir4}), 64'(3'b111));

    // Arithmetic and logic vectors
    issue_single("add_carry", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 5'b10100});
    issue_single("sub_ovf",   3'b001, 32'h8000_0000, 32'h0000_0001, {32'h7FFF_FFFF, 5'b00010});
    issue_single("sub_brw",   3'b001, 32'h0000_0000, 32'h0000_0001, {32'hFFFF_FFFF, 5'b01100});
    issue_single("xnor",      3'b110, 32'h0F0F_0F0F, 32'hF0F0_F0F0, {32'h0000_0000, 5'b10000});
    issue_single("nand",      3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'h0000_0000, 5'b10000});
    issue_single("nor",       3'b010, 32'h0000_0000, 32'h0000_0000, {32'hFFFF_FFFF, 5'b01000});

    // Opcode 111
`ifdef PIPELINED_ALU_SAT_EN
    issue_single("sat_pos", 3'b111, 32'h7FFF_FFFF, 32'h0000_0001, {32'h7FFF_FFFF, 5'b00010});
    issue_single("sat_neg", 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 5'b01010});
    issue_single("sat_none", 3'b111, 32'h0000_0005, 32'h0000_0003, {32'h0000_0008, 5'b00000});
`else
    issue_single("op7_err", 3'b111, 32'h7FFF_FFFF, 32'h0000_0001, {32'h0000_0000, 5'b10001});
`endif

    // Back-to-back stream with a 3-cycle stall on the output
    sent = 0;
    got  = 0;
    hold = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        in_op = bp_op[sent];
        in_a  = bp_a[sent];
        in_b  = bp_b[sent];
      end
      #1;
      acc  = in_valid && ir2;
      take = ov2 && out_ready;
      if (cyc >= 4 && cyc <= 6) begin
        chk("bp_stall_ready", 64'(ir2), 64'(0));
        if (cyc == 4) hold = {ov2, res2};
        else chk("bp_stall_hold", 64'({ov2, res2}), 64'(hold));
      end
      if (take) begin
        if (got < 6) chk($sformatf("bp_res%0d", got), 64'(res2), 64'(bp_exp[got]));
        got++;
      end
      @(posedge clk);
      if (acc) sent++;
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_sent", 64'(sent), 64'(6));
    chk("bp_got", 64'(got), 64'(6));
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("bp_no_dup", 64'(ov2), 64'(0));
    end

    // Reset with two operations in flight
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 3'b000;
    in_a     = 32'h0000_0001;
    in_b     = 32'h0000_0002;
    @(negedge clk);
    in_a     = 32'h0000_0010;
    in_b     = 32'h0000_0020;
    @(negedge clk);
    chk("mid_inflight", 64'(ov2), 64'(1));
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(ir2), 64'(0));
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 64'(ov2), 64'(0));
    chk("mid_rst_res", 64'(res2), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_rise", 64'(ir2), 64'(1));
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("mid_rst_quiet", 64'(ov2), 64'(0));
    end

    // Depth sweep again after the mid-stream reset
    issue_single("add_carry2", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, {32'h0000_0000, 5'b10100});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
